// File: rtl/au_sequencer.sv
// Sequencer for the add/subtract unit: loads A and B over a shared bus, then captures sum/carry/ovf.
// Latency: a start accepted on edge k gives a done pulse in cycle k+4+AU_LAT (k+5 when AU_LAT=1).
// Backpressure: start is taken only while busy=0; a start seen while busy is dropped, never queued.
// Optional feature: define SATURATE_EN to clamp an overflowing result to signed saturation by A's sign.
module au_sequencer #(
    parameter int WIDTH  = 8,
    parameter int AU_LAT = 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             start,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] op_bus,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_o,
    output logic             au_sub,
    input  logic [WIDTH-1:0] au_sum,
    input  logic             au_carry,
    input  logic             au_ovf,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Counter is 4 bits wide, enough for the 1..15 cycle AU latency range.
    localparam logic [3:0] LAT = 4'(AU_LAT);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic             sub_r;
    logic [3:0]       cnt;

    // The opcode stays on the AU select line from LOAD_A through DONE.
    assign au_sub = sub_r;

    // State register; CLR aborts any operation immediately.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Operands and opcode are latched only when a request is accepted.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            a_r   <= '0;
            b_r   <= '0;
            sub_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            a_r   <= a_in;
            b_r   <= b_in;
            sub_r <= sub_in;
        end
    end

    // Wait counter: loaded in LOAD_B, counts down to 1 while waiting for the AU.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)                              cnt <= '0;
        else if (state == S_LOAD_B)           cnt <= LAT;
        else if (state == S_WAIT && cnt > 1)  cnt <= cnt - 4'd1;
    end

    // Result capture from the AU; these registers move only in CAPTURE or on CLR.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == S_CAPTURE) begin
`ifdef SATURATE_EN
            if (au_ovf)
                result <= a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
            else
                result <= au_sum;
`else
            result <= au_sum;
`endif
            carry  <= au_carry;
            ovf    <= au_ovf;
        end
    end

    // Next-state and strobe decode; only one load strobe is active per state.
    always_comb begin
        state_nx = state;
        op_bus   = '0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_o     = 1'b0;
        done     = 1'b0;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE:    if (start) state_nx = S_LOAD_A;
            S_LOAD_A: begin
                op_bus   = a_r;
                ld_a     = 1'b1;
                state_nx = S_LOAD_B;
            end
            S_LOAD_B: begin
                op_bus   = b_r;
                ld_b     = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT:    if (cnt <= 4'd1) state_nx = S_CAPTURE;
            S_CAPTURE: begin
                ld_o     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

endmodule
